mult_div: RTL and testbench

//   Iterative multiply/divide unit with architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MFHI/MFLO, MTHI/MTLO.

---
 rtl/mult_div_if.sv | 28 ++
 rtl/mult_div.sv | 145 ++++++++++++++
 tb/tb_mult_div.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
// Handshake and data bundle between the pipeline control/datapath and the
// multiply/divide unit.
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, In1, In2, mthi, mtlo, wdata,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, In1, In2, mthi, mtlo, wdata,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are reduced to magnitudes at launch; one bit is processed per
// cycle (shift-add multiply or restoring divide), and a final cycle applies
// the sign correction and commits hi/lo.
module mult_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clock,
    input  logic       reset,
    mult_div_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_t;

    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic               is_div_q;
    logic               neg_res_q;   // sign of product / quotient
    logic               neg_rem_q;   // sign of remainder (dividend sign)
    logic [WIDTH-1:0]   opnd_q;      // multiplicand (mul) or divisor (div)
    logic [WIDTH-1:0]   orig_in1_q;  // unnegated dividend for divide-by-zero
    logic [2*WIDTH-1:0] acc_q;       // {upper, lower} working register
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;

    logic               in_signed;
    logic               s1;
    logic               s2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // Operand magnitudes and one iteration of each datapath.
    always_comb begin
        in_signed = ~bus.op[0];
        s1        = in_signed & bus.In1[WIDTH-1];
        s2        = in_signed & bus.In2[WIDTH-1];
        mag1      = s1 ? -bus.In1 : bus.In1;
        mag2      = s2 ? -bus.In2 : bus.In2;

        // Multiplier sits in the low half and is consumed LSB first.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        // Remainder in the high half, dividend/quotient shifting through the low half.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (!div_trial[WIDTH]) begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        prod_fixed = neg_res_q ? -acc_q : acc_q;
        quo_fixed  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fixed  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO architectural state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            opnd_q     <= '0;
            orig_in1_q <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        // start wins over a simultaneous mthi/mtlo
                        is_div_q   <= bus.op[1];
                        orig_in1_q <= bus.In1;
                        neg_res_q  <= s1 ^ s2;
                        neg_rem_q  <= s1;
                        count_q    <= '0;
                        busy_q     <= 1'b1;
                        if (bus.op[1]) begin
                            opnd_q  <= mag2;
                            acc_q   <= {{WIDTH{1'b0}}, mag1};
                            state_q <= StDiv;
                        end else begin
                            opnd_q  <= mag1;
                            acc_q   <= {{WIDTH{1'b0}}, mag2};
                            state_q <= StMul;
                        end
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                StMul, StDiv: begin
                    acc_q   <= (state_q == StMul) ? mul_next : div_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) state_q <= StFix;
                end
                StFix: begin
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= prod_fixed;
                    end else if (opnd_q == '0) begin
                        lo_q       <= '1;
                        hi_q       <= orig_in1_q;
                        div_zero_q <= 1'b1;
                    end else begin
                        // Overflow case (-2^(W-1) / -1) falls out of the negation naturally.
                        lo_q <= quo_fixed;
                        hi_q <= rem_fixed;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: the driver pushes model results at launch,
// the monitor pops and compares whenever done is presented.
module tb_mult_div;
    localparam int W = 32;
    localparam int LAT = W + 1;  // edges from the start edge to the done edge

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           issue;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    exp_t sb[$];
    logic [W-1:0] last_lo;

    mult_div_if #(.WIDTH(W)) bus ();

    mult_div #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached (act=running, req=finished)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the architectural definition.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb64;
        int     sa32;
        int     sb32;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb64 = longint'($signed(b));
        sa32 = $signed(a);
        sb32 = $signed(b);
        e.dz = 1'b0;
        e.issue = 0;
        case (op)
            2'b00: begin
                p = 64'(sa * sb64);
                {e.hi, e.lo} = p;
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = p;
            end
            2'b10: begin
                if (b == 0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 0;
                end else begin
                    e.lo = sa32 / sb32; e.hi = sa32 % sb32;
                end
            end
            default: begin
                if (b == 0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Called at a negedge: present the op, push the expectation, drop start
    // after the sampling edge and scramble the operands.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(op, a, b);
        e.issue = cyc + 1;
        last_lo = e.lo;
        bus.op = op; bus.In1 = a; bus.In2 = b; bus.start = 1'b1;
        sb.push_back(e);
        @(negedge clock);
        bus.start = 1'b0;
        bus.op = 2'($urandom); bus.In1 = $urandom; bus.In2 = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!bus.busy) return;
            @(negedge clock);
        end
        check("busy_timeout", 64'(bus.busy), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compare each done against the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(bus.done), 64'd0);
            end else begin
                e = sb.pop_front();
                check("hi", 64'(bus.hi), 64'(e.hi));
                check("lo", 64'(bus.lo), 64'(e.lo));
                check("div_zero", 64'(bus.div_zero), 64'(e.dz));
                check("latency", 64'(cyc - e.issue), 64'(LAT));
                check("busy_cycles", 64'(busy_run), 64'(LAT));
                check("busy_at_done", 64'(bus.busy), 64'd0);
            end
            busy_run = 0;
        end else begin
            if (bus.div_zero) check("div_zero_no_done", 64'(bus.div_zero), 64'd0);
            if (bus.busy) busy_run++;
            else busy_run = 0;
        end
    end

    initial begin
        bus.start = 0; bus.op = 0; bus.In1 = 0; bus.In2 = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.wdata = 0;
        last_lo = 0;
        repeat (3) @(negedge clock);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed corner cases, issued back to back.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
        issue(2'b00, -32'sd3, 32'd7);                wait_idle();
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);  wait_idle();
        issue(2'b10, -32'sd7, 32'd2);                wait_idle();
        issue(2'b11, 32'd100, 32'd7);                wait_idle();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);  wait_idle();
        issue(2'b11, 32'd5, 32'd0);                  wait_idle();
        issue(2'b10, -32'sd5, 32'd0);                wait_idle();

        // Start/mthi/operand changes mid-operation are ignored.
        issue(2'b00, 32'h0001_2345, -32'sd999);
        repeat (9) @(negedge clock);
        bus.start = 1; bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'h1234;
        bus.In1 = $urandom; bus.In2 = $urandom; bus.op = 2'b11;
        @(negedge clock);
        bus.start = 0; bus.mthi = 0; bus.mtlo = 0;
        wait_idle();
        @(negedge clock);

        // mthi alone, then both, in IDLE.
        bus.mthi = 1; bus.wdata = 32'h1234;
        @(negedge clock);
        bus.mthi = 0;
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        check("mthi_lo_kept", 64'(bus.lo), 64'(last_lo));
        bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'hA5A5_5A5A;
        @(negedge clock);
        bus.mthi = 0; bus.mtlo = 0;
        check("mthilo_hi", 64'(bus.hi), 64'hA5A5_5A5A);
        check("mthilo_lo", 64'(bus.lo), 64'hA5A5_5A5A);

        // start together with mthi/mtlo: the writes are dropped.
        bus.mthi = 1; bus.mtlo = 1; bus.wdata = 32'hDEAD_BEEF;
        issue(2'b01, 32'd3, 32'd4);
        bus.mthi = 0; bus.mtlo = 0;
        wait_idle();

        // Reset in the middle of a divide discards it.
        issue(2'b10, 32'h7654_3210, 32'd13);
        repeat (17) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        void'(sb.pop_back());
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        issue(2'b10, -32'sd1000, 32'd7); wait_idle();

        // Randomized operations, mostly back to back.
        for (int n = 0; n < 60; n++) begin
            issue(2'($urandom), pick(), pick());
            wait_idle();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
